// File: rtl/riscv_opcodes_pkg.sv
// Shared RISC-V opcode definitions: register index type and load funct3 encodings.
package riscv_opcodes_pkg;

    typedef logic [4:0] rsd_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

endpackage

// File: rtl/riscv_ld_align.sv
// Load data alignment: picks the addressed byte/half/word/double out of the
// XLEN-aligned bus word and sign- or zero-extends it to XLEN.
module riscv_ld_align
    import riscv_opcodes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3_i,
    input  logic [2:0]      lsb_i,
    input  logic [XLEN-1:0] q_i,
    output logic [XLEN-1:0] d_o
);

    logic [2:0]        off;
    logic [XLEN-1:0]   sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;

    always_comb begin
        // Bit 2 of the offset only selects a word lane on a 64-bit bus.
        off = (XLEN == 64) ? lsb_i : {1'b0, lsb_i[1:0]};
        sh  = q_i >> {off, 3'b000};
        b_s = sh[7:0];
        h_s = sh[15:0];
        w_s = sh[31:0];
        case (func3_i)
            LB:      d_o = XLEN'(b_s);
            LH:      d_o = XLEN'(h_s);
            LW:      d_o = XLEN'(w_s);
            LBU:     d_o = XLEN'(sh[7:0]);
            LHU:     d_o = XLEN'(sh[15:0]);
            LWU:     d_o = (XLEN == 64) ? XLEN'(sh[31:0]) : '0;
            LD:      d_o = (XLEN == 64) ? sh : '0;
            default: d_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_wb.sv
// Write-back stage: registers ALU/CSR or aligned load results onto the RF
// write port and stalls upstream while a load response is outstanding.
module riscv_wb
    import riscv_opcodes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_valid_i,
    input  rsd_t            mem_rd_i,
    input  logic [XLEN-1:0] mem_r_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_ld_func3_i,
    input  logic [2:0]      mem_adr_lsb_i,
    input  logic            mem_exception_i,
    input  logic            dmem_ack_i,
    input  logic            dmem_err_i,
    input  logic [XLEN-1:0] dmem_q_i,
    output logic            wb_stall_o,
    output logic            wb_exception_o,
    output rsd_t            rf_dst_o,
    output logic [XLEN-1:0] rf_dst_d_o,
    output logic            rf_we_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e          state_q, state_d;
    rsd_t            ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [2:0]      ld_lsb_q, ld_lsb_d;
    logic            we_q, we_d;
    logic            exc_q, exc_d;
    rsd_t            dst_q, dst_d;
    logic [XLEN-1:0] data_q, data_d;

    logic [2:0]      al_f3;
    logic [2:0]      al_lsb;
    logic [XLEN-1:0] al_data;

    // While waiting, alignment must use the captured load attributes.
    assign al_f3  = (state_q == S_WAIT) ? ld_f3_q  : mem_ld_func3_i;
    assign al_lsb = (state_q == S_WAIT) ? ld_lsb_q : mem_adr_lsb_i;

    riscv_ld_align #(.XLEN(XLEN)) u_align (
        .func3_i (al_f3),
        .lsb_i   (al_lsb),
        .q_i     (dmem_q_i),
        .d_o     (al_data)
    );

    assign wb_stall_o = rst_ni & ((state_q == S_WAIT) |
                        (mem_valid_i & mem_is_load_i & ~mem_exception_i &
                         ~dmem_ack_i & ~dmem_err_i));

    always_comb begin
        state_d  = state_q;
        ld_rd_d  = ld_rd_q;
        ld_f3_d  = ld_f3_q;
        ld_lsb_d = ld_lsb_q;
        we_d     = 1'b0;
        exc_d    = 1'b0;
        dst_d    = dst_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid_i) begin
                    if (mem_exception_i) begin
                        exc_d = 1'b1;
                    end else if (!mem_is_load_i) begin
                        we_d   = (mem_rd_i != '0);
                        dst_d  = mem_rd_i;
                        data_d = mem_r_i;
                    end else if (dmem_err_i) begin
                        exc_d = 1'b1;
                    end else if (dmem_ack_i) begin
                        we_d   = (mem_rd_i != '0);
                        dst_d  = mem_rd_i;
                        data_d = al_data;
                    end else begin
                        ld_rd_d  = mem_rd_i;
                        ld_f3_d  = mem_ld_func3_i;
                        ld_lsb_d = mem_adr_lsb_i;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A bus error overrides a simultaneous ack.
                if (dmem_err_i) begin
                    exc_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (dmem_ack_i) begin
                    we_d    = (ld_rd_q != '0);
                    dst_d   = ld_rd_q;
                    data_d  = al_data;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ld_rd_q  <= '0;
            ld_f3_q  <= '0;
            ld_lsb_q <= '0;
            we_q     <= 1'b0;
            exc_q    <= 1'b0;
            dst_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_lsb_q <= ld_lsb_d;
            we_q     <= we_d;
            exc_q    <= exc_d;
            dst_q    <= dst_d;
            data_q   <= data_d;
        end
    end

    assign rf_we_o        = we_q;
    assign wb_exception_o = exc_q;
    assign rf_dst_o       = dst_q;
    assign rf_dst_d_o     = data_q;

endmodule

// File: tb/tb_riscv_wb.sv
// Bench for riscv_wb (XLEN=32): directed sequences, a load-alignment vector
// table and randomized traffic against a transaction-level reference model.
module tb_riscv_wb;
    import riscv_opcodes_pkg::*;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            mem_valid_i, mem_is_load_i, mem_exception_i;
    rsd_t            mem_rd_i;
    logic [XLEN-1:0] mem_r_i;
    logic [2:0]      mem_ld_func3_i, mem_adr_lsb_i;
    logic            dmem_ack_i, dmem_err_i;
    logic [XLEN-1:0] dmem_q_i;
    logic            wb_stall_o, wb_exception_o, rf_we_o;
    rsd_t            rf_dst_o;
    logic [XLEN-1:0] rf_dst_d_o;

    riscv_wb #(.XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_r_i(mem_r_i),
        .mem_is_load_i(mem_is_load_i), .mem_ld_func3_i(mem_ld_func3_i),
        .mem_adr_lsb_i(mem_adr_lsb_i), .mem_exception_i(mem_exception_i),
        .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .dmem_q_i(dmem_q_i),
        .wb_stall_o(wb_stall_o), .wb_exception_o(wb_exception_o),
        .rf_dst_o(rf_dst_o), .rf_dst_d_o(rf_dst_d_o), .rf_we_o(rf_we_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        mem_valid_i = 0; mem_is_load_i = 0; mem_exception_i = 0;
        mem_rd_i = '0; mem_r_i = '0; mem_ld_func3_i = '0; mem_adr_lsb_i = '0;
        dmem_ack_i = 0; dmem_err_i = 0; dmem_q_i = '0;
    endtask

    task automatic load_in(input rsd_t rd, input logic [2:0] f3, input logic [2:0] lsb);
        mem_valid_i = 1; mem_is_load_i = 1; mem_exception_i = 0;
        mem_rd_i = rd; mem_ld_func3_i = f3; mem_adr_lsb_i = lsb;
    endtask

    // Reference: extract size bytes at byte offset, then extend arithmetically.
    function automatic logic [31:0] ref_ld(input logic [2:0] f3, input logic [2:0] lsb,
                                           input logic [31:0] q);
        longint v;
        int     sz;
        bit     sgn;
        logic [63:0] r;
        case (f3)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: begin sz = 4; sgn = 1; end
            3'd4: begin sz = 1; sgn = 0; end
            3'd5: begin sz = 2; sgn = 0; end
            default: return 32'h0;
        endcase
        v = (longint'(q) >> (8 * (lsb % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (sgn && v >= longint'(64'd1 << (8 * sz - 1))) v = v - longint'(64'd1 << (8 * sz));
        r = v;
        return r[31:0];
    endfunction

    typedef struct {
        logic [2:0]  f3;
        logic [2:0]  lsb;
        logic [31:0] q;
        logic [4:0]  rd;
        logic [31:0] exp_d;
        logic        exp_we;
    } vec_t;

    vec_t vecs[12];

    initial begin
        idle_in();

        vecs[0]  = '{LB,  3'd3, 32'h80FF_0000, 5'd1,  32'hFFFF_FF80, 1'b1};
        vecs[1]  = '{LBU, 3'd3, 32'h80FF_0000, 5'd2,  32'h0000_0080, 1'b1};
        vecs[2]  = '{LH,  3'd2, 32'h8001_0000, 5'd3,  32'hFFFF_8001, 1'b1};
        vecs[3]  = '{LHU, 3'd2, 32'h8001_0000, 5'd4,  32'h0000_8001, 1'b1};
        vecs[4]  = '{LW,  3'd0, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b1};
        vecs[5]  = '{LB,  3'd0, 32'h0000_007F, 5'd6,  32'h0000_007F, 1'b1};
        vecs[6]  = '{LH,  3'd0, 32'h1234_ABCD, 5'd7,  32'hFFFF_ABCD, 1'b1};
        vecs[7]  = '{LD,  3'd0, 32'h1234_5678, 5'd8,  32'h0000_0000, 1'b1};
        vecs[8]  = '{LWU, 3'd0, 32'h8765_4321, 5'd9,  32'h0000_0000, 1'b1};
        vecs[9]  = '{3'b111, 3'd0, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1'b1};
        vecs[10] = '{LBU, 3'd1, 32'h0000_AB00, 5'd11, 32'h0000_00AB, 1'b1};
        vecs[11] = '{LB,  3'd2, 32'h0055_0000, 5'd0,  32'h0000_0055, 1'b0};

        // Reset state
        #12;
        chk("rst_we", rf_we_o, 0);
        chk("rst_exc", wb_exception_o, 0);
        chk("rst_dst", rf_dst_o, 0);
        chk("rst_d", rf_dst_d_o, 0);
        chk("rst_stall", wb_stall_o, 0);
        rst_ni = 1;
        tick();

        // ALU writeback
        mem_valid_i = 1; mem_rd_i = 5'd5; mem_r_i = 32'h1234_5678;
        #1 chk("alu_stall", wb_stall_o, 0);
        tick();
        idle_in();
        chk("alu_we", rf_we_o, 1);
        chk("alu_dst", rf_dst_o, 5);
        chk("alu_d", rf_dst_d_o, 32'h1234_5678);
        tick();
        chk("alu_we_drop", rf_we_o, 0);
        chk("alu_d_hold", rf_dst_d_o, 32'h1234_5678);

        // Zero-wait load vector table
        for (int i = 0; i < 12; i++) begin
            load_in(vecs[i].rd, vecs[i].f3, vecs[i].lsb);
            dmem_ack_i = 1; dmem_q_i = vecs[i].q;
            #1 chk($sformatf("vec%0d_stall", i), wb_stall_o, 0);
            tick();
            idle_in();
            chk($sformatf("vec%0d_we", i), rf_we_o, vecs[i].exp_we);
            chk($sformatf("vec%0d_d", i), rf_dst_d_o, vecs[i].exp_d);
        end
        tick();

        // Waited load: issue + 3 stalled cycles, ack on the third
        load_in(5'd7, LH, 3'd2);
        #1 chk("wait_stall_issue", wb_stall_o, 1);
        tick();
        // Upstream presents garbage while waiting; it must be ignored.
        mem_valid_i = 1; mem_is_load_i = 0; mem_rd_i = 5'd9; mem_r_i = 32'hAAAA_AAAA;
        mem_ld_func3_i = LB; mem_adr_lsb_i = 3'd0;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("wait_stall_%0d", c), wb_stall_o, 1);
            tick();
            chk($sformatf("wait_we_%0d", c), rf_we_o, 0);
        end
        dmem_ack_i = 1; dmem_q_i = 32'h8001_0000;
        #1 chk("wait_stall_ack", wb_stall_o, 1);
        tick();
        idle_in();
        #1 chk("wait_stall_after", wb_stall_o, 0);
        chk("wait_we", rf_we_o, 1);
        chk("wait_dst", rf_dst_o, 7);
        chk("wait_d", rf_dst_d_o, 32'hFFFF_8001);
        tick();
        chk("wait_we_drop", rf_we_o, 0);

        // Bus error with ack in WAIT
        load_in(5'd12, LW, 3'd0);
        tick();
        idle_in();
        dmem_err_i = 1; dmem_ack_i = 1; dmem_q_i = 32'h1111_1111;
        tick();
        idle_in();
        #1 chk("err_stall", wb_stall_o, 0);
        chk("err_exc", wb_exception_o, 1);
        chk("err_we", rf_we_o, 0);
        chk("err_d_hold", rf_dst_d_o, 32'hFFFF_8001);
        tick();
        chk("err_exc_drop", wb_exception_o, 0);

        // x0 destination and pre-existing exception
        mem_valid_i = 1; mem_rd_i = 5'd0; mem_r_i = 32'hCAFE_F00D;
        tick();
        chk("x0_we", rf_we_o, 0);
        load_in(5'd3, LW, 3'd0);
        mem_exception_i = 1;
        #1 chk("exc_stall", wb_stall_o, 0);
        tick();
        idle_in();
        chk("exc_pulse", wb_exception_o, 1);
        chk("exc_we", rf_we_o, 0);
        tick();
        chk("exc_drop", wb_exception_o, 0);

        // Reset in WAIT
        load_in(5'd14, LW, 3'd0);
        tick();
        idle_in();
        #1 chk("rw_stall_pre", wb_stall_o, 1);
        #2 rst_ni = 0;
        #1;
        chk("rw_stall", wb_stall_o, 0);
        chk("rw_dst", rf_dst_o, 0);
        chk("rw_d", rf_dst_d_o, 0);
        chk("rw_we", rf_we_o, 0);
        tick();
        rst_ni = 1;
        tick();
        dmem_ack_i = 1; dmem_q_i = 32'h5555_5555;
        #1 chk("rw_stall_ack", wb_stall_o, 0);
        tick();
        idle_in();
        chk("rw_stray_we", rf_we_o, 0);
        chk("rw_stray_d", rf_dst_d_o, 0);

        // Randomized traffic vs. outstanding-transaction model
        begin
            bit          pend = 0;
            logic [4:0]  p_rd = 0;
            logic [2:0]  p_f3 = 0, p_lsb = 0;
            logic [4:0]  e_dst = 0;
            logic [31:0] e_d = 0;
            bit          e_we, e_exc, e_stall;
            bit          v, ld, ex, ack, err;
            logic [4:0]  rd;
            logic [2:0]  f3, lsb;
            logic [31:0] r, q;
            for (int n = 0; n < 2000; n++) begin
                v   = ($urandom_range(0, 9) < 7);
                ld  = $urandom_range(0, 1);
                ex  = ($urandom_range(0, 9) == 0);
                ack = ($urandom_range(0, 9) < 4);
                err = ($urandom_range(0, 9) == 0);
                rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                f3  = 3'($urandom_range(0, 7));
                lsb = 3'($urandom_range(0, 7));
                if (f3 == LH || f3 == LHU) lsb[0] = 1'b0;
                if (f3 == LW || f3 == LWU || f3 == LD) lsb[1:0] = 2'b00;
                r = $urandom;
                q = $urandom;
                mem_valid_i = v; mem_is_load_i = ld; mem_exception_i = ex;
                mem_rd_i = rd; mem_r_i = r; mem_ld_func3_i = f3; mem_adr_lsb_i = lsb;
                dmem_ack_i = ack; dmem_err_i = err; dmem_q_i = q;

                e_stall = pend || (v && ld && !ex && !ack && !err);
                #1 chk("rnd_stall", wb_stall_o, e_stall);

                e_we = 0; e_exc = 0;
                if (pend) begin
                    if (err) begin
                        e_exc = 1; pend = 0;
                    end else if (ack) begin
                        e_we = (p_rd != 0); e_dst = p_rd; e_d = ref_ld(p_f3, p_lsb, q); pend = 0;
                    end
                end else if (v) begin
                    if (ex) e_exc = 1;
                    else if (!ld) begin
                        e_we = (rd != 0); e_dst = rd; e_d = r;
                    end else if (err) e_exc = 1;
                    else if (ack) begin
                        e_we = (rd != 0); e_dst = rd; e_d = ref_ld(f3, lsb, q);
                    end else begin
                        pend = 1; p_rd = rd; p_f3 = f3; p_lsb = lsb;
                    end
                end
                tick();
                chk("rnd_we", rf_we_o, e_we);
                chk("rnd_exc", wb_exception_o, e_exc);
                chk("rnd_dst", rf_dst_o, e_dst);
                chk("rnd_d", rf_dst_d_o, e_d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
